// File: rtl/ap_ctrl_sequencer.sv
// ap_ctrl_sequencer: drives ap_start/ap_continue into an HLS top, timestamps each handshake and reports per-transaction latency.
// Optional macro AP_CTRL_CHAIN_EN selects ap_ctrl_chain mode (ap_continue = ap_done & ~cont_stall).
module ap_ctrl_sequencer #(
  parameter int CNT_W = 32,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic [CNT_W-1:0] num_trans,
  output logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_continue,
  input  logic             cont_stall,
  output logic             lat_valid,
  output logic [CNT_W-1:0] lat_data,
  output logic [CNT_W-1:0] done_cnt,
  output logic             finish,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISHED} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] n_q;
  logic [CNT_W-1:0] n_nxt;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] issued_nxt;
  logic [CNT_W-1:0] done_nxt;
  logic [CNT_W-1:0] latency;
  logic [CNT_W-1:0] ts_mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [OW-1:0]    occ;
  logic [OW-1:0]    occ_nxt;
  logic             hs;
  logic             comp;
  logic             in_run;
  logic             occ_zero;
  logic             bypass;
  logic             pop;
  logic             push;
  logic             comp_ok;
  logic             stray;
  logic             go_accept;
  logic             start_nxt;

`ifdef AP_CTRL_CHAIN_EN
  assign ap_continue = ap_done & ~cont_stall;
  assign comp        = ap_done & ap_continue;
`else
  logic unused_cont_stall;
  assign ap_continue       = 1'b1;
  assign comp              = ap_done;
  assign unused_cont_stall = cont_stall;
`endif

  // A completion with an empty FIFO is only legal when it can take this cycle's timestamp directly.
  assign hs         = ap_start & ap_ready;
  assign in_run     = (state == ISSUE) || (state == DRAIN);
  assign occ_zero   = (occ == '0);
  assign bypass     = comp & hs & occ_zero & in_run;
  assign pop        = comp & ~occ_zero & in_run;
  assign comp_ok    = bypass | pop;
  assign stray      = comp & ~comp_ok;
  assign push       = hs & ~bypass;
  assign go_accept  = go & ((state == IDLE) || (state == FINISHED));
  assign n_nxt      = go_accept ? num_trans : n_q;
  assign issued_nxt = go_accept ? '0 : issued + CNT_W'(hs);
  assign done_nxt   = done_cnt + CNT_W'(comp_ok);
  assign occ_nxt    = occ + OW'(push) - OW'(pop);
  assign latency    = bypass ? '0 : cycle_cnt - ts_mem[rd_ptr];

  // ap_start is held as long as the issue conditions hold, so it only drops after a handshake.
  assign start_nxt  = (state_nxt == ISSUE) && (issued_nxt < n_nxt) && (occ_nxt < OW'(DEPTH));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, FINISHED: begin
        if (go) begin
          state_nxt = (num_trans == '0) ? FINISHED : ISSUE;
        end
      end
      ISSUE: begin
        if (done_nxt == n_q) begin
          state_nxt = FINISHED;
        end else if (issued_nxt == n_q) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (done_nxt == n_q) begin
          state_nxt = FINISHED;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    finish = (state == FINISHED);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
      n_q       <= '0;
      issued    <= '0;
      done_cnt  <= '0;
      ap_start  <= 1'b0;
      lat_valid <= 1'b0;
      lat_data  <= '0;
      err       <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      n_q       <= n_nxt;
      issued    <= issued_nxt;
      done_cnt  <= go_accept ? '0 : done_nxt;
      ap_start  <= start_nxt;
      lat_valid <= comp_ok;
      if (comp_ok) begin
        lat_data <= latency;
      end
      if (stray) begin
        err <= 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      occ <= occ_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      ts_mem[wr_ptr] <= cycle_cnt;
    end
  end

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Self-checking bench for ap_ctrl_sequencer: randomized HLS responder plus a queue-based latency scoreboard.
// Honours AP_CTRL_CHAIN_EN when the design is built with it.
module tb_ap_ctrl_sequencer;

  localparam int CNT_W = 8;
  localparam int DEPTH = 8;
  localparam int MASK  = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             go;
  logic [CNT_W-1:0] num_trans;
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_continue;
  logic             cont_stall;
  logic             lat_valid;
  logic [CNT_W-1:0] lat_data;
  logic [CNT_W-1:0] done_cnt;
  logic             finish;
  logic             err;

  int checks = 0;
  int errors = 0;

  // Reference model: cycle counter value, outstanding timestamps and run bookkeeping.
  int cur_cnt;
  int tb_cyc = 0;
  int m_n;
  int m_issued;
  int m_done;
  int m_phase;
  bit m_err;
  bit hold_start;
  int hs_q[$];
  int obs_lat[$];

  ap_ctrl_sequencer #(.CNT_W(CNT_W), .DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .go          (go),
    .num_trans   (num_trans),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .ap_continue (ap_continue),
    .cont_stall  (cont_stall),
    .lat_valid   (lat_valid),
    .lat_data    (lat_data),
    .done_cnt    (done_cnt),
    .finish      (finish),
    .err         (err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_reset();
    cur_cnt    = 0;
    m_n        = 0;
    m_issued   = 0;
    m_done     = 0;
    m_phase    = 0;
    m_err      = 1'b0;
    hold_start = 1'b0;
    hs_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; go = 1'b0; num_trans = '0;
    ap_ready = 1'b0; ap_done = 1'b0; cont_stall = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // One clock of stimulus; updates the model and compares all observable outputs.
  task automatic step(input bit g, input int ntr, input bit rdy, input bit dn, input bit stl);
    bit exp_cont;
    bit hs;
    bit cmp;
    bit e_valid;
    bit bypass;
    bit was_run;
    int e_lat;
    go = g; num_trans = ntr[CNT_W-1:0]; ap_ready = rdy; ap_done = dn; cont_stall = stl;
    #1;
`ifdef AP_CTRL_CHAIN_EN
    exp_cont = dn & ~stl;
`else
    exp_cont = 1'b1;
`endif
    checks++;
    if (ap_continue !== exp_cont) begin
      errors++;
      $display("[TB] FAIL ap_continue: got %b expected %b (cycle %0d)", ap_continue, exp_cont, tb_cyc);
    end
    if (hold_start) begin
      checks++;
      if (ap_start !== 1'b1) begin
        errors++;
        $display("[TB] FAIL start_withdrawn: got %b expected 1 (cycle %0d)", ap_start, tb_cyc);
      end
    end
    was_run = (m_phase == 1);
    hs      = (ap_start === 1'b1) && rdy;
    cmp     = dn && exp_cont;
    e_valid = 1'b0;
    e_lat   = 0;
    bypass  = 1'b0;
    if (cmp) begin
      if (was_run && hs_q.size() > 0) begin
        e_valid = 1'b1;
        e_lat   = (cur_cnt - hs_q.pop_front()) & MASK;
      end else if (was_run && hs) begin
        e_valid = 1'b1;
        bypass  = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      if (e_valid) m_done++;
    end
    if (hs) begin
      m_issued++;
      if (!bypass) hs_q.push_back(cur_cnt);
      checks++;
      if (!was_run || m_issued > m_n || hs_q.size() > DEPTH) begin
        errors++;
        $display("[TB] FAIL handshake_bounds: got issued=%0d outstanding=%0d expected issued<=%0d outstanding<=%0d",
                 m_issued, hs_q.size(), m_n, DEPTH);
      end
    end
    hold_start = (ap_start === 1'b1) && !hs;
    if (was_run && m_done == m_n) m_phase = 2;
    if (g && !was_run) begin
      m_n = ntr; m_issued = 0; m_done = 0;
      m_phase = (ntr == 0) ? 2 : 1;
    end
    @(posedge clock);
    cur_cnt = (cur_cnt + 1) & MASK;
    tb_cyc++;
    @(negedge clock);
    if (lat_valid === 1'b1) obs_lat.push_back(int'(lat_data));
    checks++;
    if (lat_valid !== e_valid) begin
      errors++;
      $display("[TB] FAIL lat_valid: got %b expected %b (cycle %0d)", lat_valid, e_valid, tb_cyc);
    end
    if (e_valid) begin
      checks++;
      if (lat_data !== e_lat[CNT_W-1:0]) begin
        errors++;
        $display("[TB] FAIL lat_data: got %0d expected %0d (cycle %0d)", lat_data, e_lat, tb_cyc);
      end
    end
    checks++;
    if (done_cnt !== m_done[CNT_W-1:0]) begin
      errors++;
      $display("[TB] FAIL done_cnt: got %0d expected %0d (cycle %0d)", done_cnt, m_done, tb_cyc);
    end
    checks++;
    if (finish !== ((m_phase == 2) ? 1'b1 : 1'b0)) begin
      errors++;
      $display("[TB] FAIL finish: got %b expected %b (cycle %0d)", finish, (m_phase == 2), tb_cyc);
    end
    checks++;
    if (err !== m_err) begin
      errors++;
      $display("[TB] FAIL err: got %b expected %b (cycle %0d)", err, m_err, tb_cyc);
    end
  endtask

  // HLS-like responder: in-order completions, each at least lmin..lmax cycles after its handshake.
  task automatic run_trans(input int n, input int lmin, input int lmax, input bit rnd_rdy,
                           input bit rnd_stl, input int budget, input string tag);
    int pend[$];
    int last;
    int t;
    int cyc;
    bit rdy;
    bit dn;
    bit stl;
    bit hs;
    bit cmp;
    last = -1;
    step(1'b1, n, 1'b0, 1'b0, 1'b0);
    cyc = 0;
    while (!(m_phase == 2 && pend.size() == 0) && cyc < budget) begin
      rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      dn  = (pend.size() > 0) ? (pend[0] <= tb_cyc) : 1'b0;
      stl = rnd_stl ? ($urandom_range(0, 2) == 0) : 1'b0;
`ifdef AP_CTRL_CHAIN_EN
      cmp = dn && !stl;
`else
      cmp = dn;
`endif
      hs = (ap_start === 1'b1) && rdy;
      if (cmp) void'(pend.pop_front());
      if (hs) begin
        t = tb_cyc + int'($urandom_range(lmin, lmax));
        if (t <= last) t = last + 1;
        pend.push_back(t);
        last = t;
      end
      step(1'b0, 0, rdy, dn, stl);
      cyc++;
    end
    checks++;
    if (m_phase != 2 || done_cnt !== n[CNT_W-1:0]) begin
      errors++;
      $display("[TB] FAIL run_%s: got done_cnt=%0d finished=%0d expected done_cnt=%0d finished=1",
               tag, done_cnt, (m_phase == 2), n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (ap_start !== 1'b0 || finish !== 1'b0 || done_cnt !== '0 || err !== 1'b0 || lat_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_values: got start=%b finish=%b done_cnt=%0d err=%b lat_valid=%b expected all 0",
               ap_start, finish, done_cnt, err, lat_valid);
    end
    step(1'b1, 5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && m_issued < 2; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    ap_ready = 1'b0;
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    checks++;
    if (ap_start !== 1'b0 || finish !== 1'b0 || done_cnt !== '0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_midrun: got start=%b finish=%b done_cnt=%0d err=%b expected all 0",
               ap_start, finish, done_cnt, err);
    end
    reset = 1'b0;
    run_trans(5, 1, 4, 1'b1, 1'b0, 200, "after_reset");
  endtask

  task automatic test_fixed_latency();
    obs_lat.delete();
    run_trans(3, 4, 4, 1'b0, 1'b0, 100, "lat4");
    checks++;
    if (obs_lat.size() != 3) begin
      errors++;
      $display("[TB] FAIL lat4_pulses: got %0d expected 3", obs_lat.size());
    end
    foreach (obs_lat[i]) begin
      checks++;
      if (obs_lat[i] != 4) begin
        errors++;
        $display("[TB] FAIL lat4_value: got %0d expected 4", obs_lat[i]);
      end
    end
  endtask

  task automatic test_depth();
    step(1'b1, 12, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (m_issued != 8 || ap_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL depth_full: got issued=%0d start=%b expected issued=8 start=0", m_issued, ap_start);
    end
    step(1'b0, 0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (m_issued != 9 || ap_start !== 1'b0) begin
      errors++;
      $display("[TB] FAIL depth_refill: got issued=%0d start=%b expected issued=9 start=0", m_issued, ap_start);
    end
    for (int i = 0; i < 100 && m_phase != 2; i++) step(1'b0, 0, 1'b1, (hs_q.size() > 0), 1'b0);
    checks++;
    if (done_cnt !== 8'd12 || finish !== 1'b1) begin
      errors++;
      $display("[TB] FAIL depth_final: got done_cnt=%0d finish=%b expected 12 and 1", done_cnt, finish);
    end
  endtask

  task automatic test_bypass_and_stray();
    do_reset();
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (err !== 1'b1 || done_cnt !== '0 || lat_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stray_idle: got err=%b done_cnt=%0d lat_valid=%b expected 1,0,0", err, done_cnt, lat_valid);
    end
    do_reset();
    step(1'b1, 1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && ap_start !== 1'b1; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (lat_valid !== 1'b1 || lat_data !== '0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bypass: got lat_valid=%b lat_data=%0d err=%b expected 1,0,0", lat_valid, lat_data, err);
    end
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    do_reset();
    step(1'b1, 1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 400 && cur_cnt != MASK - 1; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ap_start !== 1'b1 || cur_cnt != MASK - 1) begin
      errors++;
      $display("[TB] FAIL wrap_setup: got start=%b counter=%0d expected 1 and %0d", ap_start, cur_cnt, MASK - 1);
    end
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (lat_valid !== 1'b1 || lat_data !== 8'd5) begin
      errors++;
      $display("[TB] FAIL wrap_latency: got valid=%b data=%0d expected 1 and 5", lat_valid, lat_data);
    end
  endtask

  task automatic test_continue();
    do_reset();
    obs_lat.delete();
    step(1'b1, 1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (m_issued != 1) begin
      errors++;
      $display("[TB] FAIL continue_setup: got issued=%0d expected 1", m_issued);
    end
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
`ifdef AP_CTRL_CHAIN_EN
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 0, 1'b0, 1'b1, 1'b1);
      checks++;
      if (ap_continue !== 1'b0) begin
        errors++;
        $display("[TB] FAIL continue_stall: got %b expected 0", ap_continue);
      end
    end
    step(1'b0, 0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (lat_valid !== 1'b1 || lat_data !== 8'd5 || obs_lat.size() != 1) begin
      errors++;
      $display("[TB] FAIL chain_latency: got valid=%b data=%0d pulses=%0d expected 1,5,1",
               lat_valid, lat_data, obs_lat.size());
    end
`else
    step(1'b0, 0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (lat_valid !== 1'b1 || lat_data !== 8'd2 || ap_continue !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hs_ignores_stall: got valid=%b data=%0d cont=%b expected 1,2,1",
               lat_valid, lat_data, ap_continue);
    end
`endif
    step(1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      run_trans(int'($urandom_range(1, 20)), 1, int'($urandom_range(1, 12)), 1'b1, 1'b1, 1500, "random");
    end
  endtask

  task automatic test_back_to_back();
    run_trans(0, 1, 1, 1'b0, 1'b0, 10, "zero");
    run_trans(4, 1, 3, 1'b0, 1'b0, 100, "b2b_a");
    run_trans(6, 1, 9, 1'b1, 1'b0, 300, "b2b_b");
  endtask

  initial begin
    reset = 1'b1; go = 1'b0; num_trans = '0;
    ap_ready = 1'b0; ap_done = 1'b0; cont_stall = 1'b0;
    model_reset();
    test_reset();
    test_fixed_latency();
    test_depth();
    test_bypass_and_stray();
    test_wrap();
    test_continue();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ap_ctrl_sequencer.md
Name: ap_ctrl_sequencer

Overview:
- Upstream stimulus/control stage for an HLS top under co-simulation.
- Drives the ap_ctrl handshake (`ap_start`, `ap_continue`) into the DUT and counts issued and completed transactions.
- Measures per-transaction latency, from the start/ready handshake to `ap_done`.
- Raises `finish` after the programmed transaction count completes; `finish` feeds the dataflow status monitor, and the latency records feed the CSV dump path.

Parameters:
- `CNT_W`, 32: width of the free-running cycle counter, the latency values and the transaction counters.
- `DEPTH`, 8: maximum outstanding transactions; depth of the start-timestamp FIFO (power of 2, ≥2).

Ports:
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `go`  in  1  one-cycle pulse; latches `num_trans` and starts a run
- `num_trans`  in  CNT_W  number of transactions for the run
- `ap_start`  out  1  to DUT
- `ap_ready`  in  1  from DUT
- `ap_done`  in  1  from DUT
- `ap_continue`  out  1  to DUT
- `cont_stall`  in  1  holds off `ap_continue` (used only with the optional feature)
- `lat_valid`  out  1  one-cycle pulse per completed transaction
- `lat_data`  out  CNT_W  latency in cycles for that transaction
- `done_cnt`  out  CNT_W  completed transactions in the current run
- `finish`  out  1  run complete, level
- `err`  out  1  sticky protocol error

Behaviour:
- Reset (async, `reset`=1):
  - State IDLE.
  - `ap_start`=0, `lat_valid`=0, `lat_data`=0, `done_cnt`=0, `finish`=0, `err`=0.
  - Cycle counter=0; issued count=0; FIFO empty.
  - `ap_continue`=1 without the macro; with the macro it follows its combinational rule.
- Cycle counter: increments every cycle and wraps at 2^CNT_W.
  - Latency = (counter at `ap_done`) − (timestamp at handshake), mod 2^CNT_W.
- FSM states: IDLE, ISSUE, DRAIN, FINISHED.
  - IDLE: on `go`, latch `num_trans`, clear the counts, go to ISSUE. If `num_trans`=0, go directly to FINISHED.
  - ISSUE: `ap_start` rises only when issued < N and FIFO occupancy (after this cycle's pop) < DEPTH.
  - Once high, `ap_start` stays high until the handshake cycle (`ap_start`&`ap_ready`); it is never withdrawn early.
  - On handshake: push the counter value into the FIFO and increment issued.
  - When issued reaches N: `ap_start`=0 from the next cycle; go to DRAIN.
  - DRAIN: wait for completions; when `done_cnt` reaches N, go to FINISHED.
  - FINISHED: `finish`=1 (registered; asserted the cycle after the last completion) and held. `go` restarts the run: clear `finish` and counts, go to ISSUE.
- Completion event: `ap_done`=1, gated by `ap_continue` when the macro is defined.
  - Pop the FIFO head.
  - Registered outputs next cycle: `lat_valid`=1 and `lat_data`=latency.
  - `done_cnt` increments.
- Simultaneous handshake and completion with an empty FIFO:
  - Bypass; the completion consumes the same-cycle timestamp, latency 0.
  - No push/pop hazard.
- Simultaneous push and pop with a non-empty FIFO: both occur; occupancy is unchanged.
- Completion with an empty FIFO and no same-cycle handshake:
  - `err`←1 (sticky until reset).
  - No pop; `done_cnt` unchanged; `lat_valid` stays 0.
- `ap_done` while in IDLE or FINISHED: treated as a completion with an empty FIFO (`err`). Likewise, `ap_ready`=1 with `ap_start`=0 is ignored.
- `go` while in ISSUE or DRAIN: ignored.
- `lat_valid` has no backpressure; the consumer must accept every pulse.

Optional Feature:
- Macro `AP_CTRL_CHAIN_EN`.
- Defined (ap_ctrl_chain mode):
  - `ap_continue` = `ap_done` & ~`cont_stall`, combinational.
  - A completion counts only in a cycle with `ap_done`&`ap_continue`; the DUT holds `ap_done` until then.
  - Holding `cont_stall` therefore lengthens measured latency.
- Undefined (ap_ctrl_hs mode):
  - `ap_continue` is tied to 1 and `cont_stall` is ignored.
  - Every `ap_done` cycle is a completion.

Test Plan:
- Reset mid-run (after issuing 2 of 5) → next cycle: `ap_start`=0, `finish`=0, `done_cnt`=0, `err`=0; a new `go` with N=5 then completes all 5.
- `num_trans`=3; DUT `ap_ready` immediate, `ap_done` 4 cycles after each handshake → three `lat_valid` pulses with `lat_data`=4; `done_cnt`=3; `finish`=1 one cycle after the third done.
- DEPTH=8, N=12, DUT withholds `ap_done` → exactly 8 handshakes, then `ap_start` stays 0; releasing one done yields one further handshake; final `done_cnt`=12.
- `ap_done` in the same cycle as handshake, FIFO empty → `lat_data`=0, `err`=0. A stray `ap_done` in IDLE → `err`=1, `done_cnt`=0.
- Counter preset so the handshake is at 2^CNT_W−2 and done 5 cycles later → `lat_data`=5 across the wrap.
- With `AP_CTRL_CHAIN_EN`: `cont_stall`=1 for 3 cycles while `ap_done` is held → `ap_continue`=0 during the stall and a single completion counted with latency +3; without the macro → `ap_continue`=1 constantly.
